// File: rtl/sensor_ctrl_pkg.sv
// Shared encodings for the sensor command controller: command codes, response
// codes, FSM states and the measurement kind carried through a transaction.
package sensor_ctrl_pkg;

  localparam logic [2:0] CMD_STATUS = 3'b000;
  localparam logic [2:0] CMD_TEMP   = 3'b010;
  localparam logic [2:0] CMD_HUM    = 3'b011;
  localparam logic [2:0] CMD_TOG_T  = 3'b110;
  localparam logic [2:0] CMD_TOG_H  = 3'b111;

  localparam logic [7:0] RSP_STATUS_OK = 8'h07;
  localparam logic [7:0] RSP_HUM       = 8'h08;
  localparam logic [7:0] RSP_TEMP      = 8'h09;
  localparam logic [7:0] RSP_FAULT     = 8'h1F;
  localparam logic [7:0] RSP_BAD_CH    = 8'hFE;
  localparam logic [7:0] RSP_BAD_CMD   = 8'hFF;

  typedef enum logic [1:0] {ST_IDLE, ST_MEAS_REQ, ST_MEAS_WAIT, ST_RESP} state_e;
  typedef enum logic [1:0] {OP_STATUS, OP_TEMP, OP_HUM} op_e;

  // Response to a continuous-mode toggle reports the mode's new value.
  function automatic logic [7:0] toggle_code(input logic is_hum, input logic now_on);
    case ({is_hum, now_on})
      2'b01:   toggle_code = 8'h0A;
      2'b11:   toggle_code = 8'h0B;
      2'b00:   toggle_code = 8'h0C;
      default: toggle_code = 8'h0D;
    endcase
  endfunction

endpackage

// File: rtl/cont_scheduler.sv
// Continuous-mode service scheduler: free-running period timer, one pending
// tick flag and a round-robin picker over the 2*N_CH temp/hum slots.
module cont_scheduler #(
  parameter int N_CH        = 4,
  parameter int CH_W        = 2,
  parameter int CONT_PERIOD = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2*N_CH-1:0] en,
  input  logic              slot_poll,
  input  logic              slot_take,
  output logic              slot_valid,
  output logic [CH_W-1:0]   slot_ch,
  output logic              slot_is_hum
);

  localparam int NSLOT  = 2 * N_CH;
  localparam int SLOT_W = CH_W + 1;
  localparam int TMR_W  = $clog2(CONT_PERIOD);

  logic [TMR_W-1:0]  timer;
  logic              pending;
  logic              tick;
  logic              found;
  logic [SLOT_W-1:0] ptr;
  logic [SLOT_W-1:0] pick;
  logic [SLOT_W-1:0] sidx;

  assign tick = (timer == TMR_W'(CONT_PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer   <= '0;
      pending <= 1'b0;
      ptr     <= '0;
    end else begin
      timer <= tick ? '0 : timer + 1'b1;
      // A tick arriving while one is already pending is dropped.
      if (pending) pending <= !slot_poll;
      else         pending <= tick;
      if (slot_take) ptr <= pick;
    end
  end

  // Search starts one past the last served slot so every enabled slot gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sidx  = '0;
    for (int k = 1; k <= NSLOT; k++) begin
      sidx = SLOT_W'((int'(ptr) + k) % NSLOT);
      if (!found && en[sidx]) begin
        found = 1'b1;
        pick  = sidx;
      end
    end
  end

  assign slot_valid  = pending && found;
  assign slot_ch     = CH_W'(pick >> 1);
  assign slot_is_hum = pick[0];

endmodule

// File: rtl/sensor_cmd_ctrl.sv
// Host command controller for N_CH sensors: one measurement in flight at a time,
// valid/ready response channel, and timer-driven continuous temp/hum modes.
module sensor_cmd_ctrl import sensor_ctrl_pkg::*; #(
  parameter int N_CH        = 4,
  parameter int DATA_W      = 8,
  parameter int CONT_PERIOD = 50000000,
  parameter int TIMEOUT     = 1000000,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_code,
  input  logic [CH_W-1:0]   cmd_ch,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [7:0]        resp_code,
  output logic [CH_W-1:0]   resp_ch,
  output logic [DATA_W-1:0] resp_data,
  output logic              meas_req,
  output logic [CH_W-1:0]   meas_ch,
  input  logic              meas_done,
  input  logic              meas_ok,
  input  logic [DATA_W-1:0] meas_temp,
  input  logic [DATA_W-1:0] meas_hum,
  output logic [2*N_CH-1:0] cont_active
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CH_W:0] NCH_V = (CH_W + 1)'(N_CH);

  // Handshakes: a command transfers on a rising edge with cmd_valid && cmd_ready;
  // a response is held stable from resp_valid until the edge with resp_ready high.

  state_e            state, state_n;
  op_e               op_q, op_n;
  logic [CH_W-1:0]   ch_n, rch_n;
  logic [7:0]        code_n;
  logic [DATA_W-1:0] data_n;
  logic [2*N_CH-1:0] cont_n;
  logic [CNT_W-1:0]  wait_cnt, cnt_n;
  logic [CH_W:0]     tidx;
  logic              slot_poll, slot_take, slot_valid, slot_is_hum;
  logic [CH_W-1:0]   slot_ch;

  cont_scheduler #(.N_CH(N_CH), .CH_W(CH_W), .CONT_PERIOD(CONT_PERIOD)) u_sched (
    .clk         (clk),
    .rst         (rst),
    .en          (cont_active),
    .slot_poll   (slot_poll),
    .slot_take   (slot_take),
    .slot_valid  (slot_valid),
    .slot_ch     (slot_ch),
    .slot_is_hum (slot_is_hum)
  );

  assign slot_take  = slot_poll && slot_valid;
  assign cmd_ready  = (state == ST_IDLE);
  assign meas_req   = (state == ST_MEAS_REQ);
  assign resp_valid = (state == ST_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= OP_STATUS;
      meas_ch     <= '0;
      resp_code   <= '0;
      resp_ch     <= '0;
      resp_data   <= '0;
      cont_active <= '0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_n;
      op_q        <= op_n;
      meas_ch     <= ch_n;
      resp_code   <= code_n;
      resp_ch     <= rch_n;
      resp_data   <= data_n;
      cont_active <= cont_n;
      wait_cnt    <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    op_n      = op_q;
    ch_n      = meas_ch;
    code_n    = resp_code;
    rch_n     = resp_ch;
    data_n    = resp_data;
    cont_n    = cont_active;
    cnt_n     = wait_cnt;
    slot_poll = 1'b0;
    // cmd_code[0] separates the hum toggle from the temp toggle, matching slot order.
    tidx      = {cmd_ch, cmd_code[0]};
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          rch_n   = cmd_ch;
          data_n  = '0;
          state_n = ST_RESP;
          if ({1'b0, cmd_ch} >= NCH_V) begin
            code_n = RSP_BAD_CH;
          end else begin
            case (cmd_code)
              CMD_STATUS: begin op_n = OP_STATUS; ch_n = cmd_ch; state_n = ST_MEAS_REQ; end
              CMD_TEMP:   begin op_n = OP_TEMP;   ch_n = cmd_ch; state_n = ST_MEAS_REQ; end
              CMD_HUM:    begin op_n = OP_HUM;    ch_n = cmd_ch; state_n = ST_MEAS_REQ; end
              CMD_TOG_T, CMD_TOG_H: begin
                cont_n[tidx] = ~cont_active[tidx];
                code_n       = toggle_code(cmd_code[0], cont_n[tidx]);
              end
              default: code_n = RSP_BAD_CMD;
            endcase
          end
        end else begin
          slot_poll = 1'b1;
          if (slot_valid) begin
            op_n    = slot_is_hum ? OP_HUM : OP_TEMP;
            ch_n    = slot_ch;
            state_n = ST_MEAS_REQ;
          end
        end
      end
      ST_MEAS_REQ: begin
        cnt_n   = '0;
        state_n = ST_MEAS_WAIT;
      end
      ST_MEAS_WAIT: begin
        // meas_done in the final wait cycle still wins over the timeout.
        if (meas_done) begin
          rch_n   = meas_ch;
          state_n = ST_RESP;
          if (!meas_ok) begin
            code_n = RSP_FAULT;
            data_n = '0;
          end else begin
            case (op_q)
              OP_TEMP: begin code_n = RSP_TEMP; data_n = meas_temp; end
              OP_HUM:  begin code_n = RSP_HUM;  data_n = meas_hum;  end
              default: begin code_n = RSP_STATUS_OK; data_n = '0; end
            endcase
          end
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          rch_n   = meas_ch;
          code_n  = RSP_FAULT;
          data_n  = '0;
          state_n = ST_RESP;
        end else begin
          cnt_n = wait_cnt + 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sensor_cmd_ctrl.sv
// Directed bench for sensor_cmd_ctrl: a vector table of single commands plus
// hand-written sequences for reset, hold, timeout and continuous-mode service.
module tb_sensor_cmd_ctrl;

  localparam int N_CH        = 5;
  localparam int DATA_W      = 8;
  localparam int CONT_PERIOD = 20;
  localparam int TIMEOUT     = 30;
  localparam int CH_W        = 3;
  localparam int NS          = 2 * N_CH;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_code = '0;
  logic [CH_W-1:0]   cmd_ch = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [7:0]        resp_code;
  logic [CH_W-1:0]   resp_ch;
  logic [DATA_W-1:0] resp_data;
  logic              meas_req;
  logic [CH_W-1:0]   meas_ch;
  logic              meas_done = 1'b0;
  logic              meas_ok = 1'b0;
  logic [DATA_W-1:0] meas_temp = '0;
  logic [DATA_W-1:0] meas_hum = '0;
  logic [NS-1:0]     cont_active;

  int errors = 0;
  int checks = 0;

  sensor_cmd_ctrl #(.N_CH(N_CH), .DATA_W(DATA_W), .CONT_PERIOD(CONT_PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code), .cmd_ch(cmd_ch),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_code(resp_code),
    .resp_ch(resp_ch), .resp_data(resp_data),
    .meas_req(meas_req), .meas_ch(meas_ch), .meas_done(meas_done), .meas_ok(meas_ok),
    .meas_temp(meas_temp), .meas_hum(meas_hum), .cont_active(cont_active)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver tasks (all run on negedges) ----------------
  task automatic do_cmd(input logic [2:0] code, input logic [CH_W-1:0] ch);
    bit done;
    done = 1'b0;
    cmd_valid = 1'b1; cmd_code = code; cmd_ch = ch;
    for (int i = 0; i < 60 && !done; i++) begin
      if (cmd_ready) done = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("cmd_accepted", 32'(done), 32'd1);
  endtask

  task automatic wait_meas_req(output logic [CH_W-1:0] ch);
    bit seen;
    seen = 1'b0;
    ch = '0;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (meas_req) begin seen = 1'b1; ch = meas_ch; end
      else @(negedge clk);
    end
    check("meas_req_seen", 32'(seen), 32'd1);
  endtask

  task automatic give_done(input logic ok, input logic [7:0] t, input logic [7:0] h);
    meas_done = 1'b1; meas_ok = ok; meas_temp = t; meas_hum = h;
    @(negedge clk);
    meas_done = 1'b0; meas_ok = 1'b0;
  endtask

  task automatic get_resp(output logic [7:0] code, output logic [CH_W-1:0] ch,
                          output logic [7:0] data);
    bit seen;
    seen = 1'b0;
    code = '0; ch = '0; data = '0;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (resp_valid) begin seen = 1'b1; code = resp_code; ch = resp_ch; data = resp_data; end
      else @(negedge clk);
    end
    check("resp_seen", 32'(seen), 32'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]      code;
    logic [CH_W-1:0] ch;
    bit              meas;
    logic            ok;
    logic [7:0]      temp;
    logic [7:0]      hum;
    logic [7:0]      exp_code;
    logic [7:0]      exp_data;
    logic [NS-1:0]   exp_cont;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] code, input logic [CH_W-1:0] ch, input bit meas,
                              input logic ok, input logic [7:0] t, input logic [7:0] h,
                              input logic [7:0] ec, input logic [7:0] ed, input logic [NS-1:0] cont);
    vec_t v;
    v.code = code; v.ch = ch; v.meas = meas; v.ok = ok; v.temp = t; v.hum = h;
    v.exp_code = ec; v.exp_data = ed; v.exp_cont = cont;
    return v;
  endfunction

  vec_t tbl[13];

  logic [7:0]      rc, rd;
  logic [CH_W-1:0] rch, mch;
  int              n;

  initial begin
    tbl[0]  = mk(3'b010, 3'd2, 1, 1, 8'h19, 8'h77, 8'h09, 8'h19, 10'h000);
    tbl[1]  = mk(3'b011, 3'd1, 1, 1, 8'h11, 8'h55, 8'h08, 8'h55, 10'h000);
    tbl[2]  = mk(3'b000, 3'd3, 1, 1, 8'hAA, 8'hBB, 8'h07, 8'h00, 10'h000);
    tbl[3]  = mk(3'b000, 3'd4, 1, 0, 8'hAA, 8'hBB, 8'h1F, 8'h00, 10'h000);
    tbl[4]  = mk(3'b010, 3'd0, 1, 0, 8'h66, 8'h44, 8'h1F, 8'h00, 10'h000);
    tbl[5]  = mk(3'b101, 3'd0, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 10'h000);
    tbl[6]  = mk(3'b001, 3'd2, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 10'h000);
    tbl[7]  = mk(3'b100, 3'd4, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 10'h000);
    tbl[8]  = mk(3'b010, 3'd5, 0, 0, 8'h00, 8'h00, 8'hFE, 8'h00, 10'h000);
    tbl[9]  = mk(3'b110, 3'd0, 0, 0, 8'h00, 8'h00, 8'h0A, 8'h00, 10'h001);
    tbl[10] = mk(3'b111, 3'd4, 0, 0, 8'h00, 8'h00, 8'h0B, 8'h00, 10'h201);
    tbl[11] = mk(3'b110, 3'd0, 0, 0, 8'h00, 8'h00, 8'h0C, 8'h00, 10'h200);
    tbl[12] = mk(3'b111, 3'd4, 0, 0, 8'h00, 8'h00, 8'h0D, 8'h00, 10'h000);

    reset_dut();
    @(negedge clk);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_outputs", {resp_valid, meas_req, resp_code, resp_data, 10'(cont_active)}, 32'd0);

    // Table: each command presented the cycle the controller returns to IDLE.
    foreach (tbl[i]) begin
      do_cmd(tbl[i].code, tbl[i].ch);
      if (tbl[i].meas) begin
        check("meas_req_t1", 32'(meas_req), 32'd1);
        check("meas_ch", 32'(meas_ch), 32'(tbl[i].ch));
        @(negedge clk);
        give_done(tbl[i].ok, tbl[i].temp, tbl[i].hum);
        check("resp_after_done", 32'(resp_valid), 32'd1);
      end else begin
        check("resp_t1", 32'(resp_valid), 32'd1);
        check("no_meas_req", 32'(meas_req), 32'd0);
      end
      check("cont_active", 32'(cont_active), 32'(tbl[i].exp_cont));
      get_resp(rc, rch, rd);
      check($sformatf("vec%0d_code", i), 32'(rc), 32'(tbl[i].exp_code));
      check($sformatf("vec%0d_ch", i), 32'(rch), 32'(tbl[i].ch));
      check($sformatf("vec%0d_data", i), 32'(rd), 32'(tbl[i].exp_data));
    end

    // Response held stable while resp_ready is low.
    reset_dut();
    do_cmd(3'b010, 3'd2);
    check("hold_meas_ch", 32'(meas_ch), 32'd2);
    @(negedge clk);
    give_done(1'b1, 8'h19, 8'h00);
    for (int k = 0; k < 3; k++) begin
      check("hold_resp", {resp_valid, 5'(resp_ch), resp_code, resp_data}, {1'b1, 5'd2, 8'h09, 8'h19});
      @(negedge clk);
    end
    get_resp(rc, rch, rd);
    check("hold_final_code", 32'(rc), 32'h09);

    // meas_done in IDLE and in MEAS_REQ is ignored.
    meas_done = 1'b1; meas_ok = 1'b1;
    @(negedge clk);
    meas_done = 1'b0;
    check("done_idle_ignored", 32'(resp_valid), 32'd0);
    do_cmd(3'b011, 3'd1);
    give_done(1'b1, 8'h00, 8'hAA);
    check("done_req_ignored", 32'(resp_valid), 32'd0);
    give_done(1'b1, 8'h00, 8'h3C);
    get_resp(rc, rch, rd);
    check("late_done_data", 32'(rd), 32'h3C);

    // Timeout: MEAS_WAIT lasts TIMEOUT cycles, response one cycle later.
    do_cmd(3'b000, 3'd1);
    n = 0;
    while (!resp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", 32'(n), 32'(TIMEOUT + 1));
    get_resp(rc, rch, rd);
    check("timeout_resp", {rc, 5'(rch), rd}, {8'h1F, 5'd1, 8'h00});

    // Reset in the middle of MEAS_WAIT with a continuous mode enabled.
    reset_dut();
    do_cmd(3'b110, 3'd3);
    get_resp(rc, rch, rd);
    do_cmd(3'b010, 3'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_outputs", {resp_valid, meas_req, 3'(meas_ch), resp_code, 3'(resp_ch), resp_data},
          30'd0);
    check("midrst_cont", 32'(cont_active), 32'd0);

    // Continuous: temp ch0 (slot 0) and hum ch3 (slot 7); pointer starts at 0.
    reset_dut();
    do_cmd(3'b110, 3'd0);
    get_resp(rc, rch, rd);
    do_cmd(3'b111, 3'd3);
    get_resp(rc, rch, rd);
    check("cont_mask", 32'(cont_active), 32'h081);
    for (int k = 0; k < 4; k++) begin
      wait_meas_req(mch);
      check($sformatf("cont%0d_meas_ch", k), 32'(mch), (k % 2 == 0) ? 32'd3 : 32'd0);
      @(negedge clk);
      give_done(1'b1, 8'h30 + 8'(k), 8'h50 + 8'(k));
      get_resp(rc, rch, rd);
      if (k % 2 == 0)
        check($sformatf("cont%0d_resp", k), {rc, 5'(rch), rd}, {8'h08, 5'd3, 8'h50 + 8'(k)});
      else
        check($sformatf("cont%0d_resp", k), {rc, 5'(rch), rd}, {8'h09, 5'd0, 8'h30 + 8'(k)});
    end

    // Tick pending when a command is presented in IDLE: command first, slot after.
    reset_dut();
    do_cmd(3'b110, 3'd1);
    get_resp(rc, rch, rd);
    do_cmd(3'b010, 3'd0);
    repeat (22) @(negedge clk);
    give_done(1'b1, 8'h21, 8'h00);
    get_resp(rc, rch, rd);
    check("prio_first_resp", {rc, 5'(rch), rd}, {8'h09, 5'd0, 8'h21});
    do_cmd(3'b011, 3'd2);
    check("prio_cmd_meas", {7'(meas_req), 3'(meas_ch)}, {7'd1, 3'd2});
    @(negedge clk);
    give_done(1'b1, 8'h00, 8'h44);
    get_resp(rc, rch, rd);
    check("prio_cmd_resp", {rc, 5'(rch), rd}, {8'h08, 5'd2, 8'h44});
    wait_meas_req(mch);
    check("prio_slot_ch", 32'(mch), 32'd1);
    @(negedge clk);
    give_done(1'b1, 8'h66, 8'h00);
    get_resp(rc, rch, rd);
    check("prio_slot_resp", {rc, 5'(rch), rd}, {8'h09, 5'd1, 8'h66});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
